// File: rtl/collision_manager.sv
// Car-vs-object collision detection with gameplay effects: lives, effect timers,
// game-over flag and the registered trshdObjs respawn strobe for the spawner.
module collision_manager #(
    parameter int unsigned START_LIVES   = 3,
    parameter int unsigned MAX_LIVES     = 5,
    parameter int unsigned INVULN_FRAMES = 60,
    parameter int unsigned SHIELD_FRAMES = 180,
    parameter int unsigned NOS_FRAMES    = 120,
    parameter int unsigned SPIN_FRAMES   = 30
) (
    input  logic        frame_clk,
    input  logic        Reset,
    input  logic [10:0] CarX,
    input  logic [10:0] CarY,
    input  logic [10:0] CarW,
    input  logic [10:0] CarH,
    input  logic [10:0] ObjX [8],
    input  logic [10:0] ObjY [8],
    input  logic [10:0] ObjW [8],
    input  logic [10:0] ObjH [8],
    output logic [7:0]  trshdObjs,
    output logic [2:0]  lives,
    output logic        game_over,
    output logic        shield_active,
    output logic        nos_active,
    output logic        spin_active,
    output logic        hit
);

    localparam logic [7:0] HAZARD_MASK = 8'b0010_0111;

    logic [7:0] trshd_q, trshd_d;
    logic [2:0] lives_q, lives_d;
    logic       go_q, go_d;
    logic       hit_q, hit_d;
    logic [7:0] invuln_q, invuln_d;
    logic [7:0] shield_q, shield_d;
    logic [7:0] nos_q, nos_d;
    logic [7:0] spin_q, spin_d;

    logic [7:0] overlap;
    logic [7:0] hits;
    logic       loss;
    logic       gain;
    logic [3:0] lives_sum;
    logic [2:0] lives_sat;

    // 12-bit sums keep box edges from wrapping; touching edges do not count.
    always_comb begin
        overlap = '0;
        for (int unsigned i = 0; i < 8; i++) begin
            overlap[i] = ({1'b0, CarX} < ({1'b0, ObjX[i]} + {1'b0, ObjW[i]})) &&
                         ({1'b0, ObjX[i]} < ({1'b0, CarX} + {1'b0, CarW})) &&
                         ({1'b0, CarY} < ({1'b0, ObjY[i]} + {1'b0, ObjH[i]})) &&
                         ({1'b0, ObjY[i]} < ({1'b0, CarY} + {1'b0, CarH}));
        end
    end

    always_comb begin
        hits      = overlap & ~trshd_q;
        loss      = (|(hits & HAZARD_MASK)) && (shield_q == '0) && (invuln_q == '0);
        gain      = hits[4];
        lives_sum = {1'b0, lives_q} + {3'b000, gain} - {3'b000, loss};
        lives_sat = (lives_sum > 4'(MAX_LIVES)) ? 3'(MAX_LIVES) : lives_sum[2:0];
    end

    always_comb begin
        trshd_d  = '0;
        hit_d    = 1'b0;
        lives_d  = lives_q;
        go_d     = go_q;
        invuln_d = (invuln_q != '0) ? invuln_q - 8'd1 : '0;
        shield_d = (shield_q != '0) ? shield_q - 8'd1 : '0;
        nos_d    = (nos_q    != '0) ? nos_q    - 8'd1 : '0;
        spin_d   = (spin_q   != '0) ? spin_q   - 8'd1 : '0;
        if (!go_q) begin
            trshd_d = hits;
            lives_d = lives_sat;
            if (lives_sat == '0)
                go_d = 1'b1;
            if (loss) begin
                hit_d    = 1'b1;
                invuln_d = 8'(INVULN_FRAMES);
            end
            if (hits[6] && (shield_q == '0))
                spin_d = 8'(SPIN_FRAMES);
            if (hits[3])
                nos_d = 8'(NOS_FRAMES);
            if (hits[7])
                shield_d = 8'(SHIELD_FRAMES);
        end
    end

    always_ff @(posedge frame_clk or posedge Reset) begin
        if (Reset) begin
            trshd_q  <= '0;
            lives_q  <= 3'(START_LIVES);
            go_q     <= 1'b0;
            hit_q    <= 1'b0;
            invuln_q <= '0;
            shield_q <= '0;
            nos_q    <= '0;
            spin_q   <= '0;
        end else begin
            trshd_q  <= trshd_d;
            lives_q  <= lives_d;
            go_q     <= go_d;
            hit_q    <= hit_d;
            invuln_q <= invuln_d;
            shield_q <= shield_d;
            nos_q    <= nos_d;
            spin_q   <= spin_d;
        end
    end

    assign trshdObjs     = trshd_q;
    assign lives         = lives_q;
    assign game_over     = go_q;
    assign hit           = hit_q;
    assign shield_active = (shield_q != '0);
    assign nos_active    = (nos_q != '0);
    assign spin_active   = (spin_q != '0);

endmodule

// File: tb/tb_collision_manager.sv
// Directed bench for collision_manager: hazards, pickups, edge touches,
// timers, game over and asynchronous reset.
module tb_collision_manager;

    logic        frame_clk;
    logic        Reset;
    logic [10:0] CarX, CarY, CarW, CarH;
    logic [10:0] ObjX [8];
    logic [10:0] ObjY [8];
    logic [10:0] ObjW [8];
    logic [10:0] ObjH [8];
    logic [7:0]  trshdObjs;
    logic [2:0]  lives;
    logic        game_over, shield_active, nos_active, spin_active, hit;

    int n_cmp = 0;
    int n_err = 0;
    int hi_cnt;

    collision_manager #(
        .START_LIVES(3), .MAX_LIVES(5), .INVULN_FRAMES(60),
        .SHIELD_FRAMES(180), .NOS_FRAMES(120), .SPIN_FRAMES(30)
    ) dut (
        .frame_clk(frame_clk), .Reset(Reset),
        .CarX(CarX), .CarY(CarY), .CarW(CarW), .CarH(CarH),
        .ObjX(ObjX), .ObjY(ObjY), .ObjW(ObjW), .ObjH(ObjH),
        .trshdObjs(trshdObjs), .lives(lives), .game_over(game_over),
        .shield_active(shield_active), .nos_active(nos_active),
        .spin_active(spin_active), .hit(hit)
    );

    initial frame_clk = 1'b0;
    always #5 frame_clk = ~frame_clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge frame_clk);
        #1;
    endtask

    task automatic set_obj(input int s, input int x, input int y, input int w, input int h);
        ObjX[s] = 11'(x); ObjY[s] = 11'(y); ObjW[s] = 11'(w); ObjH[s] = 11'(h);
    endtask

    task automatic park(input int s);
        set_obj(s, 2000, 2000, 10, 10);
    endtask

    // One unshielded rock hit after invulnerability has lapsed, then a wait long enough for it to lapse again.
    task automatic rock_hit(input int exp_lives);
        set_obj(0, 304, 390, 32, 19);
        tick();
        chk("rock_hit_lives", 32'(lives), 32'(exp_lives));
        chk("rock_hit_pulse", 32'(hit), 1);
        park(0);
        repeat (65) tick();
    endtask

    initial begin
        Reset = 1'b1;
        CarX = 11'd300; CarY = 11'd400; CarW = 11'd40; CarH = 11'd60;
        for (int s = 0; s < 8; s++) park(s);
        tick(); tick();
        chk("rst_lives", 32'(lives), 3);
        chk("rst_trshd", 32'(trshdObjs), 0);
        chk("rst_go", 32'(game_over), 0);
        chk("rst_hit", 32'(hit), 0);
        chk("rst_shield", 32'(shield_active), 0);
        Reset = 1'b0;
        tick();
        chk("idle_trshd", 32'(trshdObjs), 0);

        // Rock hit, then held overlap re-fires every other edge under invulnerability.
        set_obj(0, 304, 390, 32, 19);
        tick();
        chk("rock_trshd", 32'(trshdObjs), 32'h01);
        chk("rock_lives", 32'(lives), 2);
        chk("rock_hit", 32'(hit), 1);
        tick();
        chk("rock_mask_trshd", 32'(trshdObjs), 0);
        chk("rock_hit_once", 32'(hit), 0);
        tick();
        chk("rock_refire", 32'(trshdObjs), 32'h01);
        chk("rock_invuln_lives", 32'(lives), 2);
        chk("rock_invuln_hit", 32'(hit), 0);
        park(0);
        repeat (70) tick();

        // Edge-touching boxes never overlap.
        set_obj(0, 340, 390, 20, 19);
        tick();
        chk("touch_right", 32'(trshdObjs), 0);
        set_obj(0, 280, 390, 20, 19);
        tick();
        chk("touch_left", 32'(trshdObjs), 0);
        set_obj(0, 304, 460, 10, 10);
        tick();
        chk("touch_bottom", 32'(trshdObjs), 0);
        chk("touch_lives", 32'(lives), 2);
        park(0);
        tick();

        // Shield pickup, rock 10 frames later absorbed, shield lasts 180 frames.
        set_obj(7, 310, 410, 10, 10);
        tick();
        chk("shield_trshd", 32'(trshdObjs), 32'h80);
        hi_cnt = shield_active ? 1 : 0;
        park(7);
        repeat (9) begin
            tick();
            if (shield_active) hi_cnt++;
        end
        set_obj(0, 304, 390, 32, 19);
        tick();
        if (shield_active) hi_cnt++;
        chk("shield_rock_trshd", 32'(trshdObjs), 32'h01);
        chk("shield_rock_lives", 32'(lives), 2);
        chk("shield_rock_hit", 32'(hit), 0);
        park(0);
        for (int k = 0; k < 250 && shield_active; k++) begin
            tick();
            if (shield_active) hi_cnt++;
        end
        chk("shield_len", 32'(hi_cnt), 180);

        // Held life pickup climbs to the ceiling and saturates.
        set_obj(4, 310, 410, 10, 10);
        repeat (6) tick();
        chk("life_climb", 32'(lives), 5);
        tick();
        chk("life_sat_trshd", 32'(trshdObjs), 32'h10);
        chk("life_sat_lives", 32'(lives), 5);
        park(4);
        repeat (65) tick();

        rock_hit(4);
        rock_hit(3);
        rock_hit(2);
        rock_hit(1);

        // Hazard and life together at lives=1 cancel out.
        set_obj(0, 304, 390, 32, 19);
        set_obj(4, 310, 410, 10, 10);
        tick();
        chk("combo_trshd", 32'(trshdObjs), 32'h11);
        chk("combo_lives", 32'(lives), 1);
        chk("combo_go", 32'(game_over), 0);
        park(0); park(4);
        repeat (65) tick();

        // Cone at lives=1 ends the game.
        set_obj(5, 310, 410, 10, 10);
        tick();
        chk("cone_trshd", 32'(trshdObjs), 32'h20);
        chk("cone_lives", 32'(lives), 0);
        chk("cone_go", 32'(game_over), 1);
        set_obj(3, 310, 410, 10, 10);
        set_obj(0, 304, 390, 32, 19);
        tick(); tick();
        chk("go_trshd", 32'(trshdObjs), 0);
        chk("go_lives", 32'(lives), 0);
        chk("go_hit", 32'(hit), 0);
        chk("go_nos", 32'(nos_active), 0);
        chk("go_sticky", 32'(game_over), 1);
        for (int s = 0; s < 8; s++) park(s);
        #2 Reset = 1'b1;
        #1;
        chk("go_rst_lives", 32'(lives), 3);
        chk("go_rst_go", 32'(game_over), 0);
        tick();
        Reset = 1'b0;
        tick();

        // Oil spin lasts exactly 30 frames.
        set_obj(6, 310, 410, 10, 10);
        tick();
        chk("oil_trshd", 32'(trshdObjs), 32'h40);
        chk("oil_spin", 32'(spin_active), 1);
        park(6);
        repeat (29) tick();
        chk("spin_last", 32'(spin_active), 1);
        tick();
        chk("spin_done", 32'(spin_active), 0);

        // NOS interrupted by an asynchronous reset between edges.
        set_obj(3, 310, 410, 10, 10);
        tick();
        chk("nos_trshd", 32'(trshdObjs), 32'h08);
        chk("nos_on", 32'(nos_active), 1);
        park(3);
        repeat (49) tick();
        chk("nos_still", 32'(nos_active), 1);
        #2 Reset = 1'b1;
        #1;
        chk("nos_async_rst", 32'(nos_active), 0);
        chk("nos_rst_lives", 32'(lives), 3);
        #1 Reset = 1'b0;
        tick(); tick();
        chk("nos_after_rst", 32'(nos_active), 0);
        chk("nos_after_trshd", 32'(trshdObjs), 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
